regfile_wb: RTL and testbench

- General-purpose register file for the 5-stage core: 32 x 32-bit, one write port, two read ports.
- The write port is the consumer of the writeback bundle registered out of the MEM/WB stage (`we`, `waddr`, `wdata`). The read ports serve ID.
- Write-through bypass is included, so a same-cycle writeback is visible to ID without a stall.
- A per-register load scoreboard raises `stall_req` when ID reads a register whose in-flight load has not yet reached writeback.

---
 rtl/regfile_wb_pkg.sv | 23 ++
 rtl/regfile_wb_sb.sv | 79 +++++++
 rtl/regfile_wb.sv | 84 ++++++++
 tb/tb_regfile_wb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared widths and constants for the register file slice
package regfile_wb_pkg;

    localparam int RegNum      = 32;
    localparam int RegBusW     = 32;
    localparam int RegAddrBusW = 5;
    localparam int SbCntW      = 2;

    typedef logic [RegBusW-1:0]     reg_bus_t;
    typedef logic [RegAddrBusW-1:0] reg_addr_t;

    localparam reg_bus_t  ZeroWord   = '0;
    localparam reg_addr_t NOPRegAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam logic RstEnable    = 1'b1;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;

endpackage

// File: rtl/regfile_wb_sb.sv
// rtl/regfile_wb_sb.sv - per-register load scoreboard and ID stall request
module regfile_sb
    import regfile_wb_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wb_load,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    input  logic          issue_load,
    input  logic [AW-1:0] issue_addr,
    input  logic          flush,
    output logic          stall_req,
    output logic          sb_ovf
);

    localparam logic [CW-1:0] CntMax = '1;

    logic [CW-1:0] cnt [NREGS];
    logic          inc;
    logic          dec;
    logic          ovf_set;
    logic          busy1;
    logic          busy2;

    assign inc = issue_load && (issue_addr != NOPRegAddr);
    assign dec = we && wb_load && (waddr != NOPRegAddr);

    // A matching inc/dec pair cancels, so saturation only counts on a lone inc
    assign ovf_set = inc && !(dec && (waddr == issue_addr)) && (cnt[issue_addr] == CntMax);

    for (genvar g = 0; g < NREGS; g++) begin : g_cnt
        if (g == 0) begin : g_zero
            assign cnt[g] = '0;
        end else begin : g_reg
            logic inc_r;
            logic dec_r;
            assign inc_r = inc && (issue_addr == AW'(g));
            assign dec_r = dec && (waddr == AW'(g));

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    cnt[g] <= '0;
                end else if (inc_r && !dec_r && cnt[g] != CntMax) begin
                    cnt[g] <= cnt[g] + 1'b1;
                end else if (dec_r && !inc_r && cnt[g] != '0) begin
                    cnt[g] <= cnt[g] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_ovf <= 1'b0;
        end else if (!flush && ovf_set) begin
            sb_ovf <= 1'b1;
        end
    end

    // A load retiring this cycle no longer blocks its reader; the bypass covers it
    assign busy1 = (cnt[raddr1] > CW'(1)) ||
                   ((cnt[raddr1] == CW'(1)) && !(dec && (waddr == raddr1)));
    assign busy2 = (cnt[raddr2] > CW'(1)) ||
                   ((cnt[raddr2] == CW'(1)) && !(dec && (waddr == raddr2)));

    assign stall_req = !rst &&
                       ((re1 && (raddr1 != NOPRegAddr) && busy1) ||
                        (re2 && (raddr2 != NOPRegAddr) && busy2));

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - 32x32 register file with writeback bypass and load scoreboard
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int NREGS = RegNum,
    parameter int DW    = RegBusW,
    parameter int AW    = RegAddrBusW,
    parameter int CW    = SbCntW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          wb_load,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    input  logic          issue_load,
    input  logic [AW-1:0] issue_addr,
    input  logic          flush,
    output logic          stall_req,
    output logic          sb_ovf
);

    logic [DW-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we == WriteEnable && waddr != NOPRegAddr) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst == RstEnable || re1 == ReadDisable || raddr1 == NOPRegAddr) begin
            rdata1 = '0;
        end else if (we == WriteEnable && waddr == raddr1) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst == RstEnable || re2 == ReadDisable || raddr2 == NOPRegAddr) begin
            rdata2 = '0;
        end else if (we == WriteEnable && waddr == raddr2) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

    regfile_sb #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (CW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wb_load    (wb_load),
        .re1        (re1),
        .raddr1     (raddr1),
        .re2        (re2),
        .raddr2     (raddr2),
        .issue_load (issue_load),
        .issue_addr (issue_addr),
        .flush      (flush),
        .stall_req  (stall_req),
        .sb_ovf     (sb_ovf)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - directed self-checking bench for regfile_wb
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        wb_load = 1'b0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;
    logic        issue_load = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        flush = 1'b0;
    logic        stall_req;
    logic        sb_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .wb_load    (wb_load),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .issue_load (issue_load),
        .issue_addr (issue_addr),
        .flush      (flush),
        .stall_req  (stall_req),
        .sb_ovf     (sb_ovf)
    );

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; wb_load = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        issue_load = 0; issue_addr = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        rst = 1; idle();
        re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 3;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 got %h exp 0", rdata1); end
            n_checks++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata2 got %h exp 0", rdata2); end
            n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_req); end
            n_checks++; if (sb_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", sb_ovf); end
            @(posedge clk); #1;
        end
        rst = 0;
        idle(); re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 31;
        @(negedge clk);
        n_checks++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL post_reset_r3 got %h exp 0", rdata1); end
        n_checks++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL post_reset_r31 got %h exp 0", rdata2); end
        tick();
    endtask

    task automatic test_write_read();
        we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        tick();
        re1 = 1; raddr1 = 5;
        @(negedge clk);
        n_checks++; if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read_r5 got %h exp deadbeef", rdata1); end
        tick();
        we = 1; waddr = 0; wdata = 32'hFFFF_FFFF; re1 = 1; raddr1 = 0;
        @(negedge clk);
        n_checks++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_bypass got %h exp 0", rdata1); end
        tick();
        re1 = 1; raddr1 = 0;
        @(negedge clk);
        n_checks++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_read got %h exp 0", rdata1); end
        re1 = 0;
        @(negedge clk);
        n_checks++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL re_off got %h exp 0", rdata1); end
        tick();
    endtask

    task automatic test_bypass();
        we = 1; waddr = 7; wdata = 32'h12345678;
        re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
        @(negedge clk);
        n_checks++; if (rdata2 !== 32'h12345678) begin n_fail++; $display("FAIL bypass_p2 got %h exp 12345678", rdata2); end
        n_checks++; if (rdata1 !== 32'h12345678) begin n_fail++; $display("FAIL bypass_p1 got %h exp 12345678", rdata1); end
        tick();
        re2 = 1; raddr2 = 7; re1 = 1; raddr1 = 5;
        @(negedge clk);
        n_checks++; if (rdata2 !== 32'h12345678) begin n_fail++; $display("FAIL stored_r7 got %h exp 12345678", rdata2); end
        n_checks++; if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_r5 got %h exp deadbeef", rdata1); end
        tick();
    endtask

    task automatic test_load_use();
        issue_load = 1; issue_addr = 9; re1 = 1; raddr1 = 9;
        @(negedge clk);
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL issue_same_cycle got %b exp 0", stall_req); end
        tick();
        for (int c = 0; c < 2; c++) begin
            re1 = 1; raddr1 = 9;
            @(negedge clk);
            n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL load_use_stall cyc %0d got %b exp 1", c, stall_req); end
            tick();
        end
        re1 = 1; raddr1 = 9; we = 1; wb_load = 1; waddr = 9; wdata = 32'hA5;
        @(negedge clk);
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL load_retire_stall got %b exp 0", stall_req); end
        n_checks++; if (rdata1 !== 32'hA5) begin n_fail++; $display("FAIL load_retire_data got %h exp a5", rdata1); end
        tick();
        re1 = 1; raddr1 = 9;
        @(negedge clk);
        n_checks++; if (dut.u_sb.cnt[9] !== 2'd0) begin n_fail++; $display("FAIL cnt9_clear got %0d exp 0", dut.u_sb.cnt[9]); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL after_retire_stall got %b exp 0", stall_req); end
        tick();
        // non-load writeback leaves the pending count alone
        issue_load = 1; issue_addr = 10;
        tick();
        we = 1; wb_load = 0; waddr = 10; wdata = 32'h55; re1 = 1; raddr1 = 10;
        @(negedge clk);
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL nonload_wb_stall got %b exp 1", stall_req); end
        tick();
        re1 = 1; raddr1 = 10;
        @(negedge clk);
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL nonload_after_stall got %b exp 1", stall_req); end
        n_checks++; if (rdata1 !== 32'h55) begin n_fail++; $display("FAIL nonload_data got %h exp 55", rdata1); end
        we = 1; wb_load = 1; waddr = 10; wdata = 32'h66;
        tick();
    endtask

    task automatic test_simul_inc_dec();
        issue_load = 1; issue_addr = 4;
        tick();
        issue_load = 1; issue_addr = 4; we = 1; wb_load = 1; waddr = 4; wdata = 32'h44;
        re1 = 1; raddr1 = 4;
        @(negedge clk);
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL simul_stall got %b exp 0", stall_req); end
        tick();
        re2 = 1; raddr2 = 4;
        @(negedge clk);
        n_checks++; if (dut.u_sb.cnt[4] !== 2'd1) begin n_fail++; $display("FAIL simul_cnt4 got %0d exp 1", dut.u_sb.cnt[4]); end
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL simul_next_stall got %b exp 1", stall_req); end
        // independent inc/dec on different registers in one cycle
        issue_load = 1; issue_addr = 6; we = 1; wb_load = 1; waddr = 4; wdata = 32'h45;
        tick();
        re1 = 1; raddr1 = 4; re2 = 1; raddr2 = 6;
        @(negedge clk);
        n_checks++; if (dut.u_sb.cnt[4] !== 2'd0) begin n_fail++; $display("FAIL diff_cnt4 got %0d exp 0", dut.u_sb.cnt[4]); end
        n_checks++; if (dut.u_sb.cnt[6] !== 2'd1) begin n_fail++; $display("FAIL diff_cnt6 got %0d exp 1", dut.u_sb.cnt[6]); end
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL diff_stall got %b exp 1", stall_req); end
        we = 1; wb_load = 1; waddr = 6; wdata = 32'h66;
        tick();
    endtask

    task automatic test_ovf_flush();
        for (int c = 0; c < 4; c++) begin
            issue_load = 1; issue_addr = 2;
            tick();
            if (c == 2) begin
                n_checks++; if (sb_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", sb_ovf); end
            end
        end
        n_checks++; if (dut.u_sb.cnt[2] !== 2'd3) begin n_fail++; $display("FAIL sat_cnt2 got %0d exp 3", dut.u_sb.cnt[2]); end
        n_checks++; if (sb_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", sb_ovf); end
        flush = 1; re1 = 1; raddr1 = 2;
        @(negedge clk);
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL flush_no_mask got %b exp 1", stall_req); end
        tick();
        re1 = 1; raddr1 = 2;
        @(negedge clk);
        n_checks++; if (dut.u_sb.cnt[2] !== 2'd0) begin n_fail++; $display("FAIL flush_cnt2 got %0d exp 0", dut.u_sb.cnt[2]); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", stall_req); end
        n_checks++; if (sb_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", sb_ovf); end
        // stale load writeback after flush must not underflow
        we = 1; wb_load = 1; waddr = 2; wdata = 32'h22;
        tick();
        n_checks++; if (dut.u_sb.cnt[2] !== 2'd0) begin n_fail++; $display("FAIL no_underflow got %0d exp 0", dut.u_sb.cnt[2]); end
    endtask

    task automatic test_reset_mid_stall();
        issue_load = 1; issue_addr = 11;
        tick();
        re1 = 1; raddr1 = 11;
        @(negedge clk);
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL pre_rst_stall got %b exp 1", stall_req); end
        rst = 1;
        #1;
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL in_rst_stall got %b exp 0", stall_req); end
        @(posedge clk); #1;
        rst = 0; re1 = 1; raddr1 = 11; re2 = 1; raddr2 = 5;
        @(negedge clk);
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL post_rst_stall got %b exp 0", stall_req); end
        n_checks++; if (sb_ovf !== 1'b0) begin n_fail++; $display("FAIL post_rst_ovf got %b exp 0", sb_ovf); end
        n_checks++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL post_rst_r5 got %h exp 0", rdata2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_load_use();
        test_simul_inc_dec();
        test_ovf_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
